// File: rtl/usr_shift_reg.sv
// usr_shift_reg: parametrised universal shift register.
// Parallel load, single-step shift/rotate/arithmetic modes, serial in/out on
// both ends, and a counted multi-step shift engine with a busy/done handshake.
// Optional feature: define USR_PARITY_EN to add a registered even-parity
// output 'par' that tracks the register contents.
module usr_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             ld,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] shamt,
`ifdef USR_PARITY_EN
   output logic             par,
`endif
   output logic [WIDTH-1:0] out,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROTL = 3'b011;
   localparam logic [2:0] M_ROTR = 3'b100;
   localparam logic [2:0] M_SRA  = 3'b101;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;

   // One step of the selected operation; hold codes return the value unchanged.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur,
                                             input logic [2:0]       m,
                                             input logic             sl,
                                             input logic             sr);
      logic [WIDTH-1:0] res;
      res = cur;
      case (m)
         M_SHL:   res = {cur[WIDTH-2:0], sr};
         M_SHR:   res = {sl, cur[WIDTH-1:1]};
         M_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         M_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
         M_SRA:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         default: res = cur;
      endcase
      return res;
   endfunction

   // Next-state, next-data and count logic for the load/step/counted-shift FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (ld) begin
               data_d = in;
            end else if (start) begin
               // Clamp so an oversized count saturates at a full-width shift.
               mode_d = mode;
               cnt_d  = (shamt > CNT_MAX) ? CNT_MAX : shamt;
               state_d = (shamt == '0) ? DONE : SHIFT;
            end else if (en) begin
               data_d = step(data_q, mode, sin_l, sin_r);
            end
         end
         SHIFT: begin
            // Latched mode, live serial inputs; the 1->0 edge ends the run.
            data_d = step(data_q, mode_q, sin_l, sin_r);
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, data, count and latched-mode registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values
      // regardless of statement order.
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

`ifdef USR_PARITY_EN
   logic par_q;

   // Registered even parity of the value being written into the register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= ^data_d;
   end

   assign par = par_q;
`endif

   assign out    = data_q;
   assign sout_l = data_q[WIDTH-1];
   assign sout_r = data_q[0];
   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_usr_shift_reg.sv
// tb_usr_shift_reg: directed-vector bench for usr_shift_reg (WIDTH=8).
module tb_usr_shift_reg;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in;
   logic             ld;
   logic             en;
   logic [2:0]       mode;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [CNT_W-1:0] shamt;
   logic [WIDTH-1:0] out;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;
`ifdef USR_PARITY_EN
   logic             par;
`endif

   int n_vec = 0;
   int n_bad = 0;

   usr_shift_reg #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .in     (in),
      .ld     (ld),
      .en     (en),
      .mode   (mode),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .start  (start),
      .shamt  (shamt),
`ifdef USR_PARITY_EN
      .par    (par),
`endif
      .out    (out),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] v);
      ld = 1'b1; in = v;
      tick();
      ld = 1'b0;
   endtask

   task automatic single(input string tag, input logic [WIDTH-1:0] init,
                         input logic [2:0] m, input logic sl, input logic sr,
                         input logic [WIDTH-1:0] exp);
      load(init);
      mode = m; sin_l = sl; sin_r = sr; en = 1'b1;
      tick();
      en = 1'b0;
      check(tag, out, exp);
   endtask

   // Runs a counted shift from edge 0 and returns how many edges elapsed
   // until done was seen (bounded).
   task automatic counted(input logic [2:0] m, input logic [CNT_W-1:0] n,
                          output int edges, output int busy_cnt);
      mode = m; shamt = n; start = 1'b1;
      tick();
      start = 1'b0;
      edges = 0; busy_cnt = 0;
      while (!done && edges < 20) begin
         if (busy) busy_cnt++;
         tick();
         edges++;
      end
   endtask

   int edges, busy_cnt;

   initial begin
      rst = 1'b0; in = 8'hA5; ld = 1'b1; en = 1'b0; mode = 3'b000;
      sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; shamt = '0;

      // Reset holds the register clear even with a load request present.
      tick(); tick();
      check("rst_out",  out,  8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
`ifdef USR_PARITY_EN
      check("rst_par", par, 1'b0);
`endif

      rst = 1'b1;
      tick();
      check("load_a5",      out,    8'hA5);
      check("load_sout_l",  sout_l, 1'b1);
      check("load_sout_r",  sout_r, 1'b1);
      check("load_busy",    busy,   1'b0);
      check("load_done",    done,   1'b0);
      ld = 1'b0;

      // Single steps.
      single("rotl_81",   8'h81, 3'b011, 1'b0, 1'b0, 8'h03);
      single("sra_81",    8'h81, 3'b101, 1'b0, 1'b0, 8'hC0);
      single("shl_81_s1", 8'h81, 3'b001, 1'b0, 1'b1, 8'h03);
      single("shr_81_s1", 8'h81, 3'b010, 1'b1, 1'b0, 8'hC0);
      single("shr_81_s0", 8'h81, 3'b010, 1'b0, 1'b1, 8'h40);
      single("rotr_01",   8'h01, 3'b100, 1'b0, 1'b0, 8'h80);
      single("sra_40",    8'h40, 3'b101, 1'b1, 1'b1, 8'h20);
      single("hold_000",  8'h3C, 3'b000, 1'b1, 1'b1, 8'h3C);
      single("hold_110",  8'h3C, 3'b110, 1'b1, 1'b1, 8'h3C);

      // Counted shift of 3 with interfering ld/en/mode during busy.
      load(8'h01);
      mode = 3'b001; sin_r = 1'b0; shamt = 3; start = 1'b1;
      tick();
      start = 1'b0;
      check("cs_e0_out",  out,  8'h01);
      check("cs_e0_busy", busy, 1'b1);
      ld = 1'b1; in = 8'hFF; en = 1'b1; mode = 3'b011;
      tick();
      check("cs_e1_out",  out,  8'h02);
      check("cs_e1_busy", busy, 1'b1);
      check("cs_e1_done", done, 1'b0);
      tick();
      check("cs_e2_out",  out,  8'h04);
      check("cs_e2_busy", busy, 1'b1);
      tick();
      check("cs_e3_out",  out,  8'h08);
      check("cs_e3_busy", busy, 1'b0);
      check("cs_e3_done", done, 1'b1);
      tick();
      check("cs_e4_out",  out,  8'h08);
      check("cs_e4_done", done, 1'b0);
      ld = 1'b0; en = 1'b0;

      // Zero count: done next cycle, never busy, data unchanged.
      load(8'h5A);
      mode = 3'b001; shamt = 0; start = 1'b1;
      tick();
      start = 1'b0;
      check("z_busy", busy, 1'b0);
      check("z_done", done, 1'b1);
      check("z_out",  out,  8'h5A);
      tick();
      check("z_done_clr", done, 1'b0);

      // Oversized count clamps to WIDTH.
      load(8'hFF);
      sin_l = 1'b0;
      counted(3'b010, 15, edges, busy_cnt);
      check("clamp_edges", edges,    8);
      check("clamp_busy",  busy_cnt, 8);
      check("clamp_out",   out,      8'h00);
      tick();

      load(8'h96);
      counted(3'b011, 9, edges, busy_cnt);
      check("rot9_edges", edges, 8);
      check("rot9_out",   out,   8'h96);
      tick();

      // A counted shift with a hold code still runs and pulses done.
      load(8'hE7);
      counted(3'b111, 2, edges, busy_cnt);
      check("hold_cs_edges", edges, 2);
      check("hold_cs_out",   out,   8'hE7);
      tick();

      // Serial input is sampled live every step of a counted shift.
      load(8'h00);
      mode = 3'b010; shamt = 3; start = 1'b1;
      tick();
      start = 1'b0; sin_l = 1'b1;
      tick();
      sin_l = 1'b0;
      tick();
      sin_l = 1'b1;
      tick();
      check("live_sin_out",  out,  8'hA0);
      check("live_sin_done", done, 1'b1);
      sin_l = 1'b0;
      tick();

      // Reset in the middle of a counted rotate-right.
      load(8'h0F);
      mode = 3'b100; shamt = 6; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("mid_e1_out", out, 8'h87);
      tick();
      check("mid_e2_out", out, 8'hC3);
      rst = 1'b0;
      #1;
      check("mid_rst_out",  out,  8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      tick();
      check("mid_rst_hold_done", done, 1'b0);
      rst = 1'b1;
      mode = 3'b001; sin_r = 1'b1; shamt = 1; start = 1'b1;
      tick();
      start = 1'b0;
      check("post_rst_busy", busy, 1'b1);
      tick();
      check("post_rst_out",  out,  8'h01);
      check("post_rst_done", done, 1'b1);
      sin_r = 1'b0;
      tick();

`ifdef USR_PARITY_EN
      load(8'h07);
      check("par_07", par, 1'b1);
      mode = 3'b001; sin_r = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      check("par_shl_out", out, 8'h0E);
      check("par_shl",     par, 1'b1);
      load(8'h03);
      check("par_03", par, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/usr_shift_reg.md
Name: usr_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's 4-bit load/shift-left register.
- Adds:
  - generic WIDTH
  - shift left/right, rotate and arithmetic modes
  - serial in/out on both ends
  - a counted multi-bit shift engine with busy/done handshake
- Used as a datapath staging register, for serialisation and for barrel-shift-by-iteration.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- CNT_W, $clog2(WIDTH+1), width of the shift-amount field; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in  in  WIDTH  parallel load data.
- ld  in  1  parallel load request.
- en  in  1  single-step shift enable, applies the operation selected by mode.
- mode  in  3  operation select:
  - 000 hold
  - 001 shift left
  - 010 shift right logical
  - 011 rotate left
  - 100 rotate right
  - 101 shift right arithmetic
  - 110/111 hold
- sin_l  in  1  serial input entering at the MSB on right shifts.
- sin_r  in  1  serial input entering at the LSB on left shifts.
- start  in  1  begin a counted shift of shamt steps using mode.
- shamt  in  CNT_W  shift count for start.
- out  out  WIDTH  register contents.
- sout_l  out  1  equals out[WIDTH-1].
- sout_r  out  1  equals out[0].
- busy  out  1  counted shift in progress.
- done  out  1  one-cycle pulse when a counted shift completes.

Behaviour:
- Reset (rst low, asynchronous):
  - out=0, busy=0, done=0, FSM=IDLE, internal count=0, latched mode=000.
  - Release is synchronous to clk.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, priority ld > start > en:
  - ld=1: out<=in; start/en ignored that cycle.
  - start=1:
    - latch mode; latch count=min(shamt, WIDTH).
    - count=0 → DONE, out unchanged; else → SHIFT, out unchanged on this edge.
  - en=1: one step of mode applied to out; stay IDLE.
  - otherwise hold.
- SHIFT:
  - Each edge applies one step of the latched mode and decrements count.
  - The edge where count goes 1→0 moves to DONE.
  - ld, en, start and live mode are ignored; sin_l/sin_r are sampled live each step.
- DONE: done=1 for exactly that cycle; next edge → IDLE. ld/start/en are ignored in DONE.
- busy=1 exactly while state==SHIFT; done=1 exactly while state==DONE. Both are decoded from registered state, so there are no glitches from inputs.
- Latency: start sampled at edge 0 with N≥1:
  - shifts occur on edges 1..N;
  - done is high between edges N and N+1;
  - a new start is accepted at edge N+2 or later.
- Step definitions (W=WIDTH):
  - shl: {out[W-2:0], sin_r}
  - shr: {sin_l, out[W-1:1]}
  - rotl: {out[W-2:0], out[W-1]}
  - rotr: {out[0], out[W-1:1]}
  - sra: {out[W-1], out[W-1:1]}
  - hold codes leave out unchanged; a counted shift with a hold code still runs and pulses done.
- shamt>WIDTH is clamped to WIDTH, so a logical shift with zero fill yields all fill bits.
- Asserting rst mid-SHIFT aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined:
  - adds output port par (1 bit), a registered even parity of out, updated on every edge that writes out;
  - reset value 0, so after reset par always equals ^out.
- Undefined: port par and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/load: WIDTH=8, rst low with in=8'hA5, ld=1 → out=8'h00. Release rst, ld=1 in=8'hA5 → out=8'hA5 next edge, busy=0, done=0.
- Single steps: out=8'h81, en=1, then mode 011 (rotl) → 8'h03. mode 101 (sra) from 8'h81 → 8'hC0. mode 001 with sin_r=1 from 8'h81 → 8'h03.
- Counted shift: out=8'h01, start=1, shamt=3, mode=001, sin_r=0 → busy high 3 cycles, out 8'h02, 8'h04, 8'h08. done pulses once 1 cycle after the last shift; en/ld pulses during busy have no effect.
- Boundary counts:
  - shamt=0 → done pulse next cycle, busy never high, out unchanged.
  - shamt=15, mode=010, sin_l=0, out=8'hFF → exactly 8 shifts, out=8'h00.
- Reset mid-operation: start rotr shamt=6 on 8'h0F, assert rst after 2 shifts → out=0, busy=0, no done. Then start accepted immediately after release.
- USR_PARITY_EN build: load 8'h07 → par=1. shl with sin_r=0 → out=8'h0E, par=1. Load 8'h03 → par=0.
